data_mem_lsu: RTL and testbench

Parametrised, byte-addressed data memory with an integrated load/store unit for the RV32 core. It accepts one request at a time over a valid/ready handshake. It decodes RV32I load/store widths from funct3 (byte/half/word, signed/unsigned) and applies byte-lane write masking. Misaligned, out-of-range and illegal-funct3 accesses are reported on an error flag. Read latency is configurable, and responses arrive on a one-cycle valid pulse. It replaces the fixed word-addressed data memory in the MEM stage.

---
 rtl/data_mem_lsu.sv | 109 ++++++++++
 tb/tb_data_mem_lsu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed data memory with an RV32I load/store unit.
// Accepts one request at a time; the response arrives READ_LAT cycles after acceptance.
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(READ_LAT + 1);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, rsp_valid_q, rsp_err_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q, rsp_rdata_q;
    logic [31:0]   rd_words [DEPTH_WORDS];

    logic          accept, resp_go, store_go, we_c, err_c, illegal, misal, oor;
    logic [2:0]    f3_c;
    logic [31:0]   addr_c, word, load_val, wdata_rep, bit_m;
    logic [AW-1:0] idx;
    logic [15:0]   half_v;
    logic [7:0]    byte_v;
    logic [3:0]    lane_m;

    assign req_ready = state_q == IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign accept    = req_ready && req_valid;

    // Live request fields while idle (READ_LAT=1 responds off the acceptance edge), captured ones otherwise
    assign we_c   = req_ready ? req_we : we_q;
    assign f3_c   = req_ready ? req_funct3 : f3_q;
    assign addr_c = req_ready ? req_addr : addr_q;
    assign idx    = addr_c[AW+1:2];

    assign illegal = we_c ? (f3_c[2] || f3_c[1:0] == 2'b11) : (f3_c[1:0] == 2'b11 || f3_c == 3'b110);
    assign misal   = (f3_c[1:0] == 2'b01 && addr_c[0]) || (f3_c[1:0] == 2'b10 && addr_c[1:0] != 2'b00);
    assign oor     = |addr_c[31:AW+2];
    assign err_c   = illegal || misal || oor;

    assign word     = rd_words[idx];
    assign half_v   = addr_c[1] ? word[31:16] : word[15:0];
    assign byte_v   = addr_c[0] ? half_v[15:8] : half_v[7:0];
    assign load_val = f3_c[1:0] == 2'b00 ? {{24{byte_v[7] & ~f3_c[2]}}, byte_v} :
                      f3_c[1:0] == 2'b01 ? {{16{half_v[15] & ~f3_c[2]}}, half_v} : word;

    assign wdata_rep = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                       req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    assign lane_m    = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                       req_funct3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign bit_m     = {{8{lane_m[3]}}, {8{lane_m[2]}}, {8{lane_m[1]}}, {8{lane_m[0]}}};
    assign store_go  = accept && req_we && !err_c;

    // Each word powers up holding its own index; reset never touches the array
    for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_word
        logic [31:0] word_q = 32'(i);
        always_ff @(posedge clk) begin
            if (store_go && idx == AW'(i)) word_q <= (word_q & ~bit_m) | (wdata_rep & bit_m);
        end
        assign rd_words[i] = word_q;
    end

    assign resp_go = (accept && READ_LAT == 1) || (state_q == WAIT && cnt_q == '0);

    always_comb begin
        state_d = state_q == IDLE ? (accept ? (READ_LAT == 1 ? RESP : WAIT) : IDLE) :
                  state_q == WAIT ? (cnt_q == '0 ? RESP : WAIT) : IDLE;
        cnt_d   = state_q == IDLE ? (accept ? CW'(READ_LAT > 1 ? READ_LAT - 2 : 0) : cnt_q) :
                  state_q == WAIT && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= resp_go;
            rsp_rdata_q <= resp_go && !we_c && !err_c ? load_val : '0;
            rsp_err_q   <= resp_go && err_c;
            if (accept) begin
                we_q   <= req_we;
                f3_q   <= req_funct3;
                addr_q <= req_addr;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: scenario tasks with a scoreboard queue of expected responses.
module tb_data_mem_lsu;
    localparam int RL = 3;

    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    int          tot = 0, bad = 0;
    logic [32:0] exp_q [$];

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } req_t;

    data_mem_lsu #(.DEPTH_WORDS(256), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output logic clean);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        clean = !rsp_valid && req_ready;
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic er, clean; int lat; logic [32:0] e;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        tot++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        tot++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
        tot++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata); end
        tot++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", rsp_err); end
        exp_q.push_back({1'b0, 32'h4});
        send(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, clean);
        e = exp_q.pop_front();
        tot++; if ({er, rd} !== e) begin bad++; $display("FAIL reset_lw got=%h/%b want=%h/%b", rd, er, e[31:0], e[32]); end
        tot++; if (lat !== RL || !clean) begin bad++; $display("FAIL reset_lat got=%0d clean=%b want=%0d", lat, clean, RL); end
    endtask

    task automatic test_extension;
        req_t t [5];
        logic [31:0] rd; logic er, clean; int lat; logic [32:0] e;
        t = '{'{1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0},
              '{1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFFFFBE, 1'b0},
              '{1'b0, 3'b100, 32'hB, 32'h0, 32'h000000DE, 1'b0},
              '{1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFFDEAD, 1'b0},
              '{1'b0, 3'b101, 32'h8, 32'h0, 32'h0000BEEF, 1'b0}};
        foreach (t[i]) begin
            exp_q.push_back({t[i].er, t[i].rd});
            send(t[i].we, t[i].f3, t[i].a, t[i].wd, rd, er, lat, clean);
            e = exp_q.pop_front();
            tot++;
            if ({er, rd} !== e || lat !== RL || !clean) begin
                bad++;
                $display("FAIL ext[%0d] got=%h/%b lat=%0d clean=%b want=%h/%b lat=%0d", i, rd, er, lat, clean, e[31:0], e[32], RL);
            end
        end
    endtask

    task automatic test_masking;
        req_t t [4];
        logic [31:0] rd; logic er, clean; int lat; logic [32:0] e;
        t = '{'{1'b1, 3'b000, 32'h1, 32'h123456AB, 32'h0, 1'b0},
              '{1'b0, 3'b010, 32'h0, 32'h0, 32'h0000AB00, 1'b0},
              '{1'b1, 3'b001, 32'h2, 32'h0000CAFE, 32'h0, 1'b0},
              '{1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEAB00, 1'b0}};
        foreach (t[i]) begin
            exp_q.push_back({t[i].er, t[i].rd});
            send(t[i].we, t[i].f3, t[i].a, t[i].wd, rd, er, lat, clean);
            e = exp_q.pop_front();
            tot++;
            if ({er, rd} !== e || lat !== RL || !clean) begin
                bad++;
                $display("FAIL mask[%0d] got=%h/%b lat=%0d clean=%b want=%h/%b lat=%0d", i, rd, er, lat, clean, e[31:0], e[32], RL);
            end
        end
    endtask

    task automatic test_faults;
        req_t t [7];
        logic [31:0] rd; logic er, clean; int lat; logic [32:0] e;
        t = '{'{1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1},
              '{1'b1, 3'b001, 32'h3, 32'h0000BEEF, 32'h0, 1'b1},
              '{1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEAB00, 1'b0},
              '{1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1},
              '{1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1},
              '{1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1},
              '{1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEAB00, 1'b0}};
        foreach (t[i]) begin
            exp_q.push_back({t[i].er, t[i].rd});
            send(t[i].we, t[i].f3, t[i].a, t[i].wd, rd, er, lat, clean);
            e = exp_q.pop_front();
            tot++;
            if ({er, rd} !== e || lat !== RL || !clean) begin
                bad++;
                $display("FAIL fault[%0d] got=%h/%b lat=%0d clean=%b want=%h/%b lat=%0d", i, rd, er, lat, clean, e[31:0], e[32], RL);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc = 0, rsp = 0;
        logic [32:0] e;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        for (int k = 0; k < 12; k++) begin
            tot++;
            if (req_ready !== (k % 4 == 0) || rsp_valid !== (k % 4 == 3)) begin
                bad++;
                $display("FAIL b2b_hs[%0d] got ready=%b valid=%b want ready=%b valid=%b", k, req_ready, rsp_valid, k % 4 == 0, k % 4 == 3);
            end
            if (req_ready && req_valid) begin
                acc++;
                exp_q.push_back({1'b0, 32'h4});
            end
            if (rsp_valid) begin
                rsp++;
                e = exp_q.size() > 0 ? exp_q.pop_front() : 33'h1_FFFFFFFF;
                tot++;
                if ({rsp_err, rsp_rdata} !== e) begin
                    bad++;
                    $display("FAIL b2b_data[%0d] got=%h/%b want=%h/%b", k, rsp_rdata, rsp_err, e[31:0], e[32]);
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        tot++;
        if (acc !== 3 || rsp !== 3 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL b2b_count got acc=%0d rsp=%0d left=%0d want 3/3/0", acc, rsp, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        logic [31:0] rd; logic er, clean; int lat; logic [32:0] e;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h28; req_wdata = 32'hA5A50001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tot++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_st got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tot++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", req_ready); end
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        tot++; if (seen !== 0) begin bad++; $display("FAIL midrst_norsp got=%0d want=0", seen); end
        exp_q.push_back({1'b0, 32'hA5A50001});
        send(1'b0, 3'b010, 32'h28, 32'h0, rd, er, lat, clean);
        e = exp_q.pop_front();
        tot++; if ({er, rd} !== e || lat !== RL || !clean) begin bad++; $display("FAIL midrst_st_kept got=%h/%b lat=%0d want=%h/%b", rd, er, lat, e[31:0], e[32]); end
        exp_q.push_back({1'b0, 32'h8});
        send(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, clean);
        e = exp_q.pop_front();
        tot++; if ({er, rd} !== e || lat !== RL || !clean) begin bad++; $display("FAIL midrst_lw got=%h/%b lat=%0d want=%h/%b", rd, er, lat, e[31:0], e[32]); end
    endtask

    initial begin
        test_reset;
        test_extension;
        test_masking;
        test_faults;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", tot, bad);
        $fatal(1);
    end
endmodule
